// File: rtl/key_debounce_pkg.sv
// Shared types, default parameters and the counter-width helper for the key debouncer.
package key_debounce_pkg;

    localparam int unsigned DEF_N_KEYS          = 4;
    localparam bit          DEF_ACTIVE_LOW      = 1'b1;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DEB_PRESS   = 3'd1,
        S_PRESSED     = 3'd2,
        S_REPEAT      = 3'd3,
        S_DEB_RELEASE = 3'd4
    } state_e;

    // Width that holds the largest terminal count of any timer.
    function automatic int unsigned cnt_width(input int unsigned d,
                                              input int unsigned h,
                                              input int unsigned r);
        int unsigned m;
        m = d;
        if (h > m) m = h;
        if (r > m) m = r;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Raw key inputs and conditioned key event outputs.
interface key_debounce_if
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS = DEF_N_KEYS
) ();
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_raw,
        input  key_level, key_press, key_release, key_repeat
    );

    modport slave (
        input  key_raw,
        output key_level, key_press, key_release, key_repeat
    );
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, debounce FSM with shared counter, hold/auto-repeat.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic CLK,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int unsigned CW        = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam bit          REPEAT_EN = (HOLD_CYCLES != 0);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = REPEAT_EN ? CW'(HOLD_CYCLES - 1) : '0;
    localparam logic [CW-1:0] REP_LAST  = (REPEAT_EN && REPEAT_CYCLES != 0) ? CW'(REPEAT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    r_sync;
    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_p;

    // Normalised pressed level from the second synchroniser stage.
    assign w_p = r_sync[1] ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_sync    <= {2{ACTIVE_LOW}};
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_p) begin
                        r_state <= S_DEB_PRESS;
                        r_cnt   <= CNT_ONE;
                    end
                end
                S_DEB_PRESS: begin
                    if (!w_p) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= S_PRESSED;
                        r_cnt   <= '0;
                        o_level <= 1'b1;
                        o_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_PRESSED: begin
                    if (!w_p) begin
                        r_state <= S_DEB_RELEASE;
                        r_cnt   <= CNT_ONE;
                    end else if (REPEAT_EN && r_cnt == HOLD_LAST) begin
                        r_state  <= S_REPEAT;
                        r_cnt    <= '0;
                        o_repeat <= 1'b1;
                    end else if (REPEAT_EN) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_REPEAT: begin
                    if (!w_p) begin
                        r_state <= S_DEB_RELEASE;
                        r_cnt   <= CNT_ONE;
                    end else if (r_cnt == REP_LAST) begin
                        r_cnt    <= '0;
                        o_repeat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DEB_RELEASE: begin
                    // A press seen mid-release returns to PRESSED and restarts hold timing.
                    if (w_p) begin
                        r_state <= S_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        o_level   <= 1'b0;
                        o_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    o_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: one independent debounce/repeat channel per raw input.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS          = DEF_N_KEYS,
    parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic           CLK,
    input  logic           rst,
    key_debounce_if.slave  bus
);

    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;
    logic [N_KEYS-1:0] w_repeat;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .CLK       (CLK),
            .rst       (rst),
            .i_raw     (bus.key_raw[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_repeat  (w_repeat[g])
        );
    end

    assign bus.key_level   = w_level;
    assign bus.key_press   = w_press;
    assign bus.key_release = w_release;
    assign bus.key_repeat  = w_repeat;

endmodule

// File: tb/tb_key_debounce.sv
// Directed + randomized bench for key_debounce against a run-length reference model.
module tb_key_debounce;

    localparam int unsigned NK   = 4;
    localparam int unsigned D    = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 5;
    localparam bit          AL   = 1'b1;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] raw = '1;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    // Reference model: level changes after D consecutive disagreeing samples;
    // repeats fall at held_since + HOLD + k*REP while the key stays pressed.
    logic [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_rep;
    int            m_run  [NK];
    int            m_held [NK];

    key_debounce_if #(.N_KEYS(NK)) bus ();
    assign bus.key_raw = raw;

    key_debounce #(
        .N_KEYS          (NK),
        .ACTIVE_LOW      (AL),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < int'(NK); k++) begin
            logic pe;
            logic was_deb;
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            m_rep[k]   = 1'b0;
            if (!rst) begin
                m_s1[k]   = AL;
                m_s2[k]   = AL;
                m_lvl[k]  = 1'b0;
                m_run[k]  = 0;
                m_held[k] = 0;
            end else begin
                pe      = m_s2[k] ^ AL;
                m_s2[k] = m_s1[k];
                m_s1[k] = raw[k];
                if (pe != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == int'(D)) begin
                        m_lvl[k] = pe;
                        m_run[k] = 0;
                        if (pe) begin
                            m_press[k] = 1'b1;
                            m_held[k]  = cyc;
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                    end
                end else begin
                    was_deb  = (m_run[k] != 0);
                    m_run[k] = 0;
                    if (m_lvl[k] && was_deb)
                        m_held[k] = cyc;
                    else if (m_lvl[k] && (cyc - m_held[k]) >= int'(HOLD) &&
                             ((cyc - m_held[k] - int'(HOLD)) % int'(REP)) == 0)
                        m_rep[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("level",   32'(bus.key_level),   32'(m_lvl));
        chk("press",   32'(bus.key_press),   32'(m_press));
        chk("release", 32'(bus.key_release), 32'(m_rel));
        chk("repeat",  32'(bus.key_repeat),  32'(m_rep));
        chk("exclusive", 32'((bus.key_press & bus.key_repeat) | (bus.key_press & bus.key_release) |
                             (bus.key_repeat & bus.key_release) | (bus.key_repeat & ~bus.key_level)), 32'd0);
    endtask

    // One clock: model updates on the edge, DUT sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        cyc++;
        model_step();
        @(negedge CLK);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold_left [NK];

        // 1. reset with all keys pressed, then fresh press after debounce
        raw = 4'h0;
        rst = 1'b0;
        ticks(3);
        chk("t1_rst_level", 32'(bus.key_level), 32'h0);
        chk("t1_rst_press", 32'(bus.key_press), 32'h0);
        rst = 1'b1;
        ticks(5);
        chk("t1_e4_press", 32'(bus.key_press), 32'h0);
        tick();
        chk("t1_e5_press", 32'(bus.key_press), 32'hF);
        chk("t1_e5_level", 32'(bus.key_level), 32'hF);
        raw = 4'hF;
        ticks(5);
        tick();
        chk("t1_release", 32'(bus.key_release), 32'hF);
        ticks(3);

        // 2. clean press on key 0
        raw = 4'hE;
        ticks(5);
        chk("t2_e4_press", 32'(bus.key_press), 32'h0);
        tick();
        chk("t2_e5_press", 32'(bus.key_press), 32'h1);
        chk("t2_e5_level", 32'(bus.key_level), 32'h1);
        tick();
        chk("t2_e6_press", 32'(bus.key_press), 32'h0);
        raw = 4'hF;
        ticks(8);

        // 3. bounce on key 0: single press at E9
        raw = 4'hE;
        ticks(3);
        raw = 4'hF;
        tick();
        raw = 4'hE;
        for (int e = 4; e <= 8; e++) begin
            tick();
            chk("t3_early_press", 32'(bus.key_press), 32'h0);
        end
        tick();
        chk("t3_e9_press", 32'(bus.key_press), 32'h1);
        raw = 4'hF;
        ticks(8);

        // 4. hold key 1: press at E5, repeats at E15, E20, E25
        raw = 4'hD;
        for (int e = 0; e <= 44; e++) begin
            tick();
            if (e == 5)  chk("t4_press", 32'(bus.key_press[1]), 32'h1);
            if (e == 14) chk("t4_no_rep_e14", 32'(bus.key_repeat[1]), 32'h0);
            if (e == 15 || e == 20 || e == 25) chk("t4_repeat", 32'(bus.key_repeat[1]), 32'h1);
            if (e == 16) chk("t4_no_rep_e16", 32'(bus.key_repeat[1]), 32'h0);
        end
        raw = 4'hF;
        for (int e = 0; e <= 20; e++) begin
            tick();
            if (e == 5) chk("t4_release", 32'(bus.key_release[1]), 32'h1);
            if (e > 5)  chk("t4_rep_after", 32'(bus.key_repeat[1]), 32'h0);
        end

        // 5. release glitch on key 2 restarts hold timing
        raw = 4'hB;
        ticks(5);
        tick();
        chk("t5_level", 32'(bus.key_level[2]), 32'h1);
        ticks(2);
        raw = 4'hF;
        ticks(2);
        raw = 4'hB;
        for (int e = 2; e <= 16; e++) begin
            tick();
            chk("t5_hold_level", 32'(bus.key_level[2]), 32'h1);
            chk("t5_no_release", 32'(bus.key_release[2]), 32'h0);
            if (e == 13) chk("t5_no_rep_e13", 32'(bus.key_repeat[2]), 32'h0);
            if (e == 14) chk("t5_repeat", 32'(bus.key_repeat[2]), 32'h1);
        end
        raw = 4'hF;
        ticks(10);

        // 6. simultaneous press on keys 0 and 3, then reset while held
        raw = 4'h6;
        ticks(5);
        tick();
        chk("t6_press", 32'(bus.key_press), 32'h9);
        ticks(3);
        rst = 1'b0;
        tick();
        chk("t6_rst_level", 32'(bus.key_level), 32'h0);
        chk("t6_rst_release", 32'(bus.key_release), 32'h0);
        ticks(2);
        rst = 1'b1;
        raw = 4'hF;
        ticks(8);

        // Randomized segments of stable levels and short bursts, with rare resets.
        for (int k = 0; k < int'(NK); k++) hold_left[k] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < int'(NK); k++) begin
                if (hold_left[k] == 0) begin
                    raw[k] = 1'($urandom_range(1, 0));
                    hold_left[k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1))
                                                               : int'($urandom_range(40, 5));
                end else begin
                    hold_left[k]--;
                end
            end
            rst = ($urandom_range(499, 0) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
